usb_fs_rx_ctrl: RTL

Full-speed USB receive sequencer that sits directly behind the data/data_n pads inside top. It runs on clock48 (4x the 12 Mb/s bit rate) and performs several steps in order:
- synchronises the two line inputs;
- recovers bit timing;
- detects SYNC;
- NRZI-decodes and unstuffs the bit stream;
- assembles bytes and frames packets on EOP;
- independently detects bus reset.

It hands a byte stream with framing strobes to the protocol layer.

---
 rtl/usb_pkg.sv | 22 ++
 rtl/usb_fs_rx_ctrl_if.sv | 22 ++
 rtl/usb_rx_dpll.sv | 38 +++
 rtl/usb_fs_rx_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared line-state, receive-FSM and PID definitions for the full-speed USB receiver
package usb_pkg;
   typedef enum logic [1:0] {
      LS_SE0 = 2'b00,
      LS_K   = 2'b01,
      LS_J   = 2'b10,
      LS_SE1 = 2'b11
   } line_t;
   typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_ERR} rx_state_t;
   localparam logic [7:0] SYNC_PAT  = 8'h80;
   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_IN    = 4'h9;
   localparam logic [3:0] PID_SOF   = 4'h5;
   localparam logic [3:0] PID_SETUP = 4'hD;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   function automatic logic pid_ok(input logic [7:0] b);
      return b[7:4] == ~b[3:0];
   endfunction
endpackage

// File: rtl/usb_fs_rx_ctrl_if.sv
// usb_fs_rx_ctrl_if: pad inputs and received-byte/framing outputs of the USB receiver
// master: receiver side (samples data/data_n, drives rx_* and bus_reset)
// slave : line driver / protocol layer side
interface usb_fs_rx_ctrl_if;
   logic       data;
   logic       data_n;
   logic [7:0] rx_byte;
   logic       rx_byte_valid;
   logic       rx_packet_start;
   logic       rx_packet_end;
   logic       rx_error;
   logic       rx_active;
   logic       bus_reset;
   modport master (
      input  data, data_n,
      output rx_byte, rx_byte_valid, rx_packet_start, rx_packet_end, rx_error, rx_active, bus_reset
   );
   modport slave (
      output data, data_n,
      input  rx_byte, rx_byte_valid, rx_packet_start, rx_packet_end, rx_error, rx_active, bus_reset
   );
endinterface

// File: rtl/usb_rx_dpll.sv
// usb_rx_dpll: line synchroniser, line-state decode and bit-phase recovery
// Ports: clock48/reset_n; i_dp/i_dn raw pads; o_line synchronised line state;
//        o_sample one-cycle mid-bit strobe; o_j2k J->K edge of the synchronised line
module usb_rx_dpll
   import usb_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = 4
) (
   input  logic  clock48,
   input  logic  reset_n,
   input  logic  i_dp,
   input  logic  i_dn,
   output line_t o_line,
   output logic  o_sample,
   output logic  o_j2k
);
   localparam int PW = CLOCKS_PER_BIT > 1 ? $clog2(CLOCKS_PER_BIT) : 1;
   logic [1:0]    r_dp;
   logic [1:0]    r_dn;
   line_t         r_prev;
   logic [PW-1:0] r_phase;
   assign o_line   = line_t'({r_dp[1], r_dn[1]});
   assign o_sample = r_phase == PW'(CLOCKS_PER_BIT / 2);
   assign o_j2k    = r_prev == LS_J && o_line == LS_K;
   // any line change realigns the phase so sampling lands late in the bit cell
   always_ff @(posedge clock48 or negedge reset_n)
      if (!reset_n) begin
         r_dp    <= '0;
         r_dn    <= '0;
         r_prev  <= LS_SE0;
         r_phase <= '0;
      end else begin
         r_dp    <= {r_dp[0], i_dp};
         r_dn    <= {r_dn[0], i_dn};
         r_prev  <= o_line;
         r_phase <= (o_line != r_prev || r_phase == PW'(CLOCKS_PER_BIT - 1)) ? '0 : r_phase + PW'(1);
      end
endmodule

// File: rtl/usb_fs_rx_ctrl.sv
// usb_fs_rx_ctrl: full-speed USB receive sequencer (SYNC, NRZI, unstuff, bytes, EOP, bus reset)
// Ports: clock48 48 MHz clock; reset_n async active-low reset;
//        bus (master) data/data_n pads in, rx_byte/rx_byte_valid/rx_packet_start/
//        rx_packet_end/rx_error/rx_active/bus_reset out
// Option: USB_RX_PID_CHECK_EN enables the first-byte PID nibble check
module usb_fs_rx_ctrl
   import usb_pkg::*;
#(
   parameter int CLOCKS_PER_BIT   = 4,
   parameter int RESET_SE0_CYCLES = 120,
   parameter int IDLE_BITS        = 8
) (
   input logic              clock48,
   input logic              reset_n,
   usb_fs_rx_ctrl_if.master bus
);
   localparam int SW = $clog2(RESET_SE0_CYCLES + 1);
   localparam int IW = $clog2(IDLE_BITS + 1);
   line_t         w_line;
   logic          w_sample;
   logic          w_j2k;
   logic          w_se0;
   logic          w_jk;
   logic          w_bit;
   logic          w_rst_hit;
   logic [7:0]    w_byte;
   logic [SW-1:0] r_se0;
   rx_state_t     r_state;
   line_t         r_last;
   logic [2:0]    r_bits;
   logic [2:0]    r_ones;
   logic [7:0]    r_shift;
   logic [IW-1:0] r_idle;
   logic          r_got;
   logic          r_eop;
   logic          r_pid_bad;
   usb_rx_dpll #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_dpll (
      .clock48  (clock48),
      .reset_n  (reset_n),
      .i_dp     (bus.data),
      .i_dn     (bus.data_n),
      .o_line   (w_line),
      .o_sample (w_sample),
      .o_j2k    (w_j2k)
   );
   assign w_se0     = w_line == LS_SE0;
   assign w_jk      = w_line == LS_J || w_line == LS_K;
   assign w_bit     = w_line == r_last;
   assign w_byte    = {w_bit, r_shift[7:1]};
   assign w_rst_hit = w_se0 && r_se0 >= SW'(RESET_SE0_CYCLES - 1);
   always_ff @(posedge clock48 or negedge reset_n)
      if (!reset_n) begin
         r_se0         <= '0;
         bus.bus_reset <= 1'b0;
      end else begin
         r_se0         <= !w_se0 ? '0 : (r_se0 == SW'(RESET_SE0_CYCLES) ? r_se0 : r_se0 + SW'(1));
         bus.bus_reset <= w_rst_hit;
      end
   always_ff @(posedge clock48 or negedge reset_n)
      if (!reset_n) begin
         r_state             <= ST_IDLE;
         r_last              <= LS_SE0;
         r_bits              <= '0;
         r_ones              <= '0;
         r_shift             <= '0;
         r_idle              <= '0;
         r_got               <= 1'b0;
         r_eop               <= 1'b0;
         r_pid_bad           <= 1'b0;
         bus.rx_byte         <= '0;
         bus.rx_byte_valid   <= 1'b0;
         bus.rx_packet_start <= 1'b0;
         bus.rx_packet_end   <= 1'b0;
         bus.rx_error        <= 1'b0;
         bus.rx_active       <= 1'b0;
      end else begin
         bus.rx_byte_valid   <= 1'b0;
         bus.rx_packet_start <= 1'b0;
         bus.rx_packet_end   <= 1'b0;
         bus.rx_error        <= 1'b0;
         // bus reset aborts silently and takes priority over any FSM step
         if (w_rst_hit) begin
            r_state       <= ST_IDLE;
            bus.rx_active <= 1'b0;
         end else case (r_state)
            ST_IDLE: if (w_j2k) begin
               r_state <= ST_SYNC;
               r_last  <= LS_J;
               r_bits  <= '0;
            end
            ST_SYNC: if (w_sample) begin
               r_last <= w_line;
               if (!w_jk || w_bit != SYNC_PAT[r_bits]) begin
                  r_state      <= ST_ERR;
                  r_idle       <= '0;
                  bus.rx_error <= 1'b1;
               end else if (r_bits == 3'd7) begin
                  r_state             <= ST_DATA;
                  r_bits              <= '0;
                  r_ones              <= '0;
                  r_got               <= 1'b0;
                  r_pid_bad           <= 1'b0;
                  bus.rx_packet_start <= 1'b1;
                  bus.rx_active       <= 1'b1;
               end else
                  r_bits <= r_bits + 3'd1;
            end
            ST_DATA: if (w_sample) begin
               r_last <= w_line;
               if (w_se0) begin
                  r_state <= ST_EOP;
                  r_eop   <= 1'b0;
               end else if (w_line == LS_SE1 || (r_ones == 3'd6 && w_bit)) begin
                  r_state           <= ST_ERR;
                  r_idle            <= '0;
                  bus.rx_packet_end <= 1'b1;
                  bus.rx_error      <= 1'b1;
                  bus.rx_active     <= 1'b0;
               end else if (r_ones == 3'd6)
                  r_ones <= '0;
               else begin
                  r_ones  <= w_bit ? r_ones + 3'd1 : 3'd0;
                  r_shift <= w_byte;
                  r_bits  <= r_bits + 3'd1;
                  if (r_bits == 3'd7) begin
                     bus.rx_byte       <= w_byte;
                     bus.rx_byte_valid <= 1'b1;
                     r_got             <= 1'b1;
`ifdef USB_RX_PID_CHECK_EN
                     if (!r_got) r_pid_bad <= !pid_ok(w_byte);
`else
                     r_pid_bad <= 1'b0;
`endif
                  end
               end
            end
            ST_EOP: if (w_sample) begin
               if (w_se0 && !r_eop)
                  r_eop <= 1'b1;
               else begin
                  r_state           <= ST_IDLE;
                  bus.rx_packet_end <= 1'b1;
                  bus.rx_active     <= 1'b0;
                  bus.rx_error      <= w_line != LS_J || r_bits != 3'd0 || !r_got || r_pid_bad;
               end
            end
            ST_ERR: if (w_sample) begin
               r_idle <= w_line == LS_J ? r_idle + IW'(1) : '0;
               if (w_line == LS_J && r_idle == IW'(IDLE_BITS - 1)) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
endmodule
